datain_pio: RTL and testbench
=============================

// Module: datain_pio
// PURPOSE
//  Avalon-MM slave input port: mirror of the 16-bit output PIO, carrying
//  external signals into the Nios II system. Synchronises the asynchronous
//  in_port bus and captures per-bit edges into a sticky register. Raises a
//  maskable, level-sensitive IRQ. Sits on the system interconnect beside
//  the output PIO with the same 2-bit word address map.
// PARAMETERS
//  DATA_WIDTH   16  width of in_port and of every register
//  SYNC_STAGES  2   flip-flop synchroniser depth on in_port (>=2)
//  EDGE_TYPE    0   0 = rising, 1 = falling, 2 = any edge sets edgecapture
// PORTS
//  clk        in   1           system clock; everything is on posedge clk
//  reset      in   1           asynchronous reset, active-high
//  address    in   2           word address of the register
//  chipselect in   1           slave select
//  read_n     in   1           active-low read strobe
//  write_n    in   1           active-low write strobe
//  writedata  in   DATA_WIDTH  write data
//  in_port    in   DATA_WIDTH  external input, asynchronous to clk
//  readdata   out  DATA_WIDTH  registered read data, 1-cycle read latency
//  irq        out  1           registered interrupt request, active-high
// BEHAVIOUR
//  Reset: all registers clear asynchronously while reset=1, with no clk
//   edge needed: sync chain, s_d, arm counter, irqmask, edgecapture,
//   readdata and irq. Both outputs are 0.
//  Sync: sync[0]<=in_port, sync[i]<=sync[i-1]; s=sync[SYNC_STAGES-1].
//   s_d<=s. The input reaches s after SYNC_STAGES rising edges.
//  Edge detect: rise=s&~s_d, fall=~s&s_d, edge=rise|fall, chosen by
//   EDGE_TYPE. The result is gated by the signal armed.
//  Arm counter: after reset it counts clk cycles up to SYNC_STAGES+1, then
//   holds at that value. armed=1 only at terminal count. This stops a high
//   in_port at reset release from producing a false edge.
//  Register map (word address):
//   0 data        RO  s, the synchronised value. Writes are ignored.
//   1 reserved    RO  reads 0. Writes are ignored.
//   2 irqmask     RW  per-bit interrupt enable.
//   3 edgecapture R/W1C  sticky edge bits. Writing 1 clears a bit; 0 keeps it.
//  Write: accepted when chipselect=1 and write_n=0 on a clk edge. No wait
//   states.
//  edgecapture bit i, next value:
//   det[i] ? 1 : (wr3 & writedata[i]) ? 0 : hold.
//   If an edge and a clear happen in the same cycle, set wins.
//  irq <= |(edgecapture & irqmask). irq goes high 1 cycle after the
//   captured bit is visible and stays high until the bit is cleared or
//   masked off.
//  Read: when chipselect=1 and read_n=0 at edge N, readdata <= mux(address)
//   at edge N, so data is valid in cycle N+1. Otherwise readdata holds.
//   A read of address 3 in the same cycle as a clear returns the value
//   before the clear.
//  Read and write asserted together: both happen; the read returns old data.
//  Reset mid-operation: any captured edges and the mask are lost, and the
//   arm counter restarts.
//  Latency, in_port to edgecapture bit: SYNC_STAGES+1 cycles. To irq: +1.
// TESTING
//  1 Reset: hold in_port=16'hFFFF through reset release -> edgecapture
//    stays 16'h0000 and irq=0 for 20 cycles; reading addr 0 returns 16'hFFFF.
//  2 Rising capture, EDGE_TYPE=0: drive in_port bit3 0->1 -> edgecapture
//    =16'h0008 after 3 cycles. With irqmask=0, irq stays 0. Write 16'h0008
//    to addr 2 -> irq=1 on the next cycle.
//  3 W1C: edgecapture=16'h0009, write 16'h0001 to addr 3 -> edgecapture
//    =16'h0008. irq stays 1 while mask=16'h0008. Write 16'h0008 to addr 3
//    -> edgecapture=0, then irq=0 one cycle later.
//  4 Clear/edge collision: new bit5 edge detected in the same cycle as a
//    write of 16'h0020 to addr 3 -> bit5 remains 1.
//  5 Read latency: read addr 2 with mask=16'hA5A5 -> readdata=16'hA5A5
//    in the following cycle. Read addr 1 -> 16'h0000.
//  6 Async reset mid-run: with mask=16'hFFFF and irq=1, assert reset
//    between clk edges -> irq, readdata, mask and capture go to 0 at once.

Source files
------------

// File: rtl/datain_pio.sv
// datain_pio: Avalon-MM slave input PIO, companion to the 16-bit output PIO.
// Synchronises the asynchronous in_port bus, captures per-bit edges into a
// sticky write-1-to-clear register and raises a maskable level IRQ.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   address               word address (0 data, 1 reserved, 2 irqmask,
//                         3 edgecapture)
//   chipselect            slave select
//   read_n, write_n       active-low read / write strobes
//   writedata             write data
//   in_port               external input, asynchronous to clk
//   readdata              registered read data, one-cycle read latency
//   irq                   registered interrupt request, active-high
module datain_pio #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [DATA_WIDTH-1:0] writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  irq
);

  localparam int unsigned ARM_TERM = SYNC_STAGES + 1;
  localparam int unsigned ARM_W    = $clog2(ARM_TERM + 1);
  localparam logic [ARM_W-1:0] ARM_TERM_V = ARM_TERM[ARM_W-1:0];

  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] s;
  logic [DATA_WIDTH-1:0] s_d;
  logic [DATA_WIDTH-1:0] det;
  logic [DATA_WIDTH-1:0] irqmask;
  logic [DATA_WIDTH-1:0] edgecapture;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [DATA_WIDTH-1:0] clr_mask;
  logic [ARM_W-1:0]      arm_cnt;
  logic                  armed;
  logic                  wr_en;
  logic                  rd_en;

  assign s     = sync_q[SYNC_STAGES-1];
  assign armed = (arm_cnt == ARM_TERM_V);
  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & ~read_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      s_d <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_d <= s;
    end
  end

  // Holding edge detection off until the chain and s_d carry real samples
  // keeps a high in_port at reset release from looking like a rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_cnt <= '0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 1'b1;
    end
  end

  always_comb begin
    det = '0;
    if (armed) begin
      if (EDGE_TYPE == 0)      det = s & ~s_d;
      else if (EDGE_TYPE == 1) det = ~s & s_d;
      else                     det = s ^ s_d;
    end
  end

  always_comb begin
    clr_mask = '0;
    if (wr_en && address == 2'd3) clr_mask = writedata;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux = s;
      2'd1:    rd_mux = '0;
      2'd2:    rd_mux = irqmask;
      default: rd_mux = edgecapture;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqmask     <= '0;
      edgecapture <= '0;
      readdata    <= '0;
      irq         <= 1'b0;
    end else begin
      if (wr_en && address == 2'd2) irqmask <= writedata;
      // A new edge overrides a simultaneous write-1-to-clear.
      edgecapture <= det | (edgecapture & ~clr_mask);
      if (rd_en) readdata <= rd_mux;
      irq <= |(edgecapture & irqmask);
    end
  end

endmodule

// File: tb/tb_datain_pio.sv
module tb_datain_pio;

  localparam int unsigned DW = 16;
  localparam int unsigned SS = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          read_n = 1'b1;
  logic          write_n = 1'b1;
  logic [DW-1:0] writedata = '0;
  logic [DW-1:0] in_port = '1;
  logic [DW-1:0] readdata;
  logic          irq;

  int n_chk = 0;
  int n_fail = 0;

  datain_pio #(.DATA_WIDTH(DW), .SYNC_STAGES(SS), .EDGE_TYPE(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Reference model: a history of in_port samples taken at each clock edge;
  // the synchronised value is the sample SS edges old, its predecessor one
  // edge older. Edges only count once SS+1 clocks have elapsed since reset.
  logic [DW-1:0] m_hist[$];
  int            m_edges;
  logic [DW-1:0] m_mask, m_cap, m_rd, m_s, m_sd, m_det, m_clr;
  logic          m_irq;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hist = {};
      for (int i = 0; i <= SS; i++) m_hist.push_back('0);
      m_edges = 0;
      m_mask = '0;
      m_cap = '0;
      m_rd = '0;
      m_irq = 1'b0;
    end else begin
      m_s = m_hist[SS-1];
      m_sd = m_hist[SS];
      m_det = (m_edges >= SS + 1) ? (m_s & ~m_sd) : '0;
      if (chipselect && !read_n) begin
        if (address == 2'd0)      m_rd = m_s;
        else if (address == 2'd1) m_rd = '0;
        else if (address == 2'd2) m_rd = m_mask;
        else                      m_rd = m_cap;
      end
      m_irq = ((m_cap & m_mask) != '0);
      m_clr = (chipselect && !write_n && address == 2'd3) ? writedata : '0;
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata;
      m_cap = m_det | (m_cap & ~m_clr);
      m_hist.push_front(in_port);
      void'(m_hist.pop_back());
      if (m_edges < 1000) m_edges++;
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("model_readdata", readdata, m_rd);
    chk("model_irq", {15'b0, irq}, {15'b0, m_irq});
  endtask

  task automatic idle();
    chipselect = 1'b0;
    read_n = 1'b1;
    write_n = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [DW-1:0] d);
    chipselect = 1'b1;
    write_n = 1'b0;
    address = a;
    writedata = d;
    tick();
    idle();
  endtask

  task automatic rd(input logic [1:0] a, output logic [DW-1:0] d);
    chipselect = 1'b1;
    read_n = 1'b0;
    address = a;
    tick();
    d = readdata;
    idle();
  endtask

  logic [DW-1:0] v;

  initial begin
    // 1: reset with in_port held high
    repeat (3) @(negedge clk);
    chk("reset_readdata", readdata, 16'h0000);
    chk("reset_irq", {15'b0, irq}, 16'h0000);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("no_false_irq", {15'b0, irq}, 16'h0000);
    end
    rd(2'd3, v); chk("no_false_edge", v, 16'h0000);
    rd(2'd0, v); chk("data_ffff", v, 16'hFFFF);

    // 2: rising capture on bit 3
    in_port = 16'h0000;
    repeat (4) tick();
    rd(2'd3, v); chk("falling_ignored", v, 16'h0000);
    in_port = 16'h0008;
    repeat (3) tick();
    rd(2'd3, v); chk("rise_bit3", v, 16'h0008);
    chk("irq_masked", {15'b0, irq}, 16'h0000);
    wr(2'd2, 16'h0008);
    chk("irq_not_yet", {15'b0, irq}, 16'h0000);
    tick();
    chk("irq_after_mask", {15'b0, irq}, 16'h0001);

    // 3: write-1-to-clear
    in_port = 16'h0009;
    repeat (3) tick();
    rd(2'd3, v); chk("cap_0009", v, 16'h0009);
    wr(2'd3, 16'h0001);
    rd(2'd3, v); chk("w1c_bit0", v, 16'h0008);
    chk("irq_held", {15'b0, irq}, 16'h0001);
    wr(2'd3, 16'h0008);
    chk("irq_lags_clear", {15'b0, irq}, 16'h0001);
    tick();
    chk("irq_cleared", {15'b0, irq}, 16'h0000);
    rd(2'd3, v); chk("cap_empty", v, 16'h0000);

    // 4: clear collides with new bit5 edge
    in_port = 16'h0029;
    tick();
    tick();
    wr(2'd3, 16'h0020);
    rd(2'd3, v); chk("set_wins", v, 16'h0020);

    // 5: read latency / reserved
    wr(2'd2, 16'hA5A5);
    rd(2'd2, v); chk("mask_a5a5", v, 16'hA5A5);
    rd(2'd1, v); chk("reserved_zero", v, 16'h0000);
    rd(2'd0, v); chk("data_0029", v, 16'h0029);

    // 6: asynchronous reset between edges
    wr(2'd2, 16'hFFFF);
    rd(2'd2, v); chk("mask_ffff", v, 16'hFFFF);
    chk("irq_before_reset", {15'b0, irq}, 16'h0001);
    #2 reset = 1'b1;
    #1;
    chk("async_irq", {15'b0, irq}, 16'h0000);
    chk("async_readdata", readdata, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    rd(2'd2, v); chk("mask_lost", v, 16'h0000);
    rd(2'd3, v); chk("cap_lost", v, 16'h0000);
    repeat (5) tick();
    rd(2'd3, v); chk("no_edge_after_rst", v, 16'h0000);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) in_port = DW'($urandom);
      chipselect = ($urandom_range(0, 3) != 0);
      read_n = $urandom_range(0, 1) == 1;
      write_n = $urandom_range(0, 2) != 0;
      address = 2'($urandom_range(0, 3));
      writedata = DW'($urandom);
      tick();
    end
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
